arm_ex_commit: RTL

//  EX->MEM pipeline stage directly downstream of the ALU. Checks the EX

---
 rtl/arm_ex_commit_pkg.sv | 25 ++
 rtl/arm_cond_eval.sv | 39 +++
 rtl/arm_ex_commit.sv | 114 +++++++++++
 3 files changed

// File: rtl/arm_ex_commit_pkg.sv
// Shared definitions for the EX->MEM commit stage: ARM condition codes,
// NZCV bit positions and the EX/MEM latch payload.
package arm_ex_commit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        rd_we;
        logic        is_mem;
        logic [31:0] store_data;
    } mem_latch_t;

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field evaluator; also used by the branch unit.
module arm_cond_eval
    import arm_ex_commit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = nzcv[NZCV_N];
        z    = nzcv[NZCV_Z];
        c    = nzcv[NZCV_C];
        v    = nzcv[NZCV_V];
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_ex_commit.sv
// EX->MEM commit stage: condition check, CPSR flag commit, EX/MEM latch,
// forwarding source and execute/skip counters.
module arm_ex_commit
    import arm_ex_commit_pkg::*;
#(
    parameter logic [3:0] CPSR_RST = 4'b0000,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             ex_valid,
    input  logic [3:0]       ex_cond,
    input  logic             ex_set_flags,
    input  logic             ex_logical,
    input  logic             ex_is_mem,
    input  logic [3:0]       ex_rd,
    input  logic             ex_rd_we,
    input  logic [31:0]      ex_store_data,
    input  logic [31:0]      alu_out,
    input  logic [3:0]       alu_cpsr,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       cpsr_nzcv,
    output logic             alu_cin,
    output logic             ex_cond_pass,
    output logic             mem_valid,
    output logic [31:0]      mem_result,
    output logic [3:0]       mem_rd,
    output logic             mem_rd_we,
    output logic             mem_is_mem,
    output logic [31:0]      mem_store_data,
    output logic             fwd_valid,
    output logic [3:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] cnt_exec,
    output logic [CNT_W-1:0] cnt_skip
);

    logic [3:0]       cpsr_q, cpsr_d;
    logic             mem_valid_q, mem_valid_d;
    mem_latch_t       mem_q, mem_d;
    logic [CNT_W-1:0] cnt_exec_q, cnt_exec_d;
    logic [CNT_W-1:0] cnt_skip_q, cnt_skip_d;
    logic             pass;
    logic             go;

    arm_cond_eval u_cond_eval (
        .cond (ex_cond),
        .nzcv (cpsr_q),
        .pass (pass)
    );

    always_comb begin
        cpsr_d      = cpsr_q;
        mem_valid_d = mem_valid_q;
        mem_d       = mem_q;
        cnt_exec_d  = cnt_exec_q;
        cnt_skip_d  = cnt_skip_q;
        go          = ex_valid & pass & !flush;

        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (!stall) begin
            mem_valid_d = go;
            // Payload is zeroed for an empty slot so X from an idle ALU never enters the latch.
            mem_d.result     = ex_valid ? alu_out       : 32'd0;
            mem_d.rd         = ex_valid ? ex_rd         : 4'd0;
            mem_d.rd_we      = ex_valid & ex_rd_we;
            mem_d.is_mem     = ex_valid & ex_is_mem;
            mem_d.store_data = ex_valid ? ex_store_data : 32'd0;
            cnt_exec_d = cnt_exec_q + {{(CNT_W-1){1'b0}}, go};
            cnt_skip_d = cnt_skip_q + {{(CNT_W-1){1'b0}}, ex_valid & !pass};
            if (go && ex_set_flags && !ex_is_mem) begin
                cpsr_d[NZCV_N] = alu_cpsr[NZCV_N];
                cpsr_d[NZCV_Z] = alu_cpsr[NZCV_Z];
                cpsr_d[NZCV_C] = alu_cpsr[NZCV_C];
                // Logical ops leave V undefined at the ALU; keep the architectural V.
                cpsr_d[NZCV_V] = ex_logical ? cpsr_q[NZCV_V] : alu_cpsr[NZCV_V];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cpsr_q      <= CPSR_RST;
            mem_valid_q <= 1'b0;
            mem_q       <= '0;
            cnt_exec_q  <= '0;
            cnt_skip_q  <= '0;
        end else begin
            cpsr_q      <= cpsr_d;
            mem_valid_q <= mem_valid_d;
            mem_q       <= mem_d;
            cnt_exec_q  <= cnt_exec_d;
            cnt_skip_q  <= cnt_skip_d;
        end
    end

    assign cpsr_nzcv      = cpsr_q;
    assign alu_cin        = cpsr_q[NZCV_C];
    assign ex_cond_pass   = pass;
    assign mem_valid      = mem_valid_q;
    assign mem_result     = mem_q.result;
    assign mem_rd         = mem_q.rd;
    assign mem_rd_we      = mem_valid_q & mem_q.rd_we;
    assign mem_is_mem     = mem_q.is_mem;
    assign mem_store_data = mem_q.store_data;
    assign fwd_valid      = mem_valid_q & mem_q.rd_we;
    assign fwd_rd         = mem_q.rd;
    assign fwd_data       = mem_q.result;
    assign cnt_exec       = cnt_exec_q;
    assign cnt_skip       = cnt_skip_q;

endmodule
